// File: rtl/mont_expo_param.sv
// mont_expo_param: modular exponentiator z = x^y mod m (m odd, m > 1).
//
// The engine is one bit-serial radix-2 Montgomery multiplier (R = 2^WIDTH).
// A left-to-right square-and-multiply FSM drives it. Each Montgomery product
// takes WIDTH+2 cycles: 1 load, WIDTH add/shift iterations, 1 correction.
// An even modulus is rejected two cycles after the start is accepted, with err=1.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all state
//   start  request; sampled only in IDLE, all operands latched on that edge
//   x      base (WIDTH), requires x < m
//   y      exponent (EXP_W), scanned MSB first
//   m      modulus (WIDTH), must be odd
//   r2     2^(2*WIDTH) mod m (WIDTH), supplied by the host
//   z      result (WIDTH), held while done=1
//   busy   high from the accepting edge until done rises
//   done   level, high from completion until the next accepted start
//   err    valid with done; 1 = even modulus rejected
//
// Build option MONT_EXPO_CONST_TIME_EN: the multiply step runs for every
// exponent bit, and its result is dropped when the bit is 0. Latency then
// does not depend on y.

module mont_expo_param #(
    parameter int WIDTH = 192,
    parameter int EXP_W = 192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [EXP_W-1:0] y,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int KW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_TOMONT, S_INIT, S_SQR, S_MUL, S_FROMMONT, S_FIN
    } state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_x, r_m, r_r2, r_xm, r_acc, r_z, r_opa, r_opb;
    logic [EXP_W-1:0] r_y;
    logic [WIDTH+1:0] r_A;
    logic [CW-1:0]    r_cnt;
    logic [KW-1:0]    r_k;
    logic             r_busy, r_done, r_err;

    logic             w_in_mm, w_mm_last, w_ybit, w_do_mul, w_k_zero;
    logic [WIDTH-1:0] w_lda, w_ldb, w_res;
    logic [WIDTH+1:0] w_add_b, w_add_m, w_corr;

    assign w_in_mm   = (r_state == S_TOMONT) || (r_state == S_INIT) || (r_state == S_SQR) ||
                       (r_state == S_MUL) || (r_state == S_FROMMONT);
    assign w_mm_last = (r_cnt == CW'(WIDTH + 1));
    assign w_ybit    = r_y[r_k];
    assign w_k_zero  = (r_k == '0);
`ifdef MONT_EXPO_CONST_TIME_EN
    assign w_do_mul  = 1'b1;
`else
    assign w_do_mul  = w_ybit;
`endif

    // With a, b < 2^WIDTH and A < 2^(WIDTH+1), A + b + m fits in WIDTH+2 bits.
    // This holds even for out-of-range operands, so the register never wraps.
    assign w_add_b = r_A + (r_opa[0] ? {2'b00, r_opb} : '0);
    assign w_add_m = w_add_b + (w_add_b[0] ? {2'b00, r_m} : '0);
    assign w_corr  = (r_A >= {2'b00, r_m}) ? (r_A - {2'b00, r_m}) : r_A;
    assign w_res   = w_corr[WIDTH-1:0];

    // Operand pair fed to the multiplier on its load cycle
    always_comb begin
        w_lda = '0;
        w_ldb = '0;
        case (r_state)
            S_TOMONT:   begin w_lda = r_x;          w_ldb = r_r2;         end
            S_INIT:     begin w_lda = WIDTH'(1);    w_ldb = r_r2;         end
            S_SQR:      begin w_lda = r_acc;        w_ldb = r_acc;        end
            S_MUL:      begin w_lda = r_acc;        w_ldb = r_xm;         end
            S_FROMMONT: begin w_lda = r_acc;        w_ldb = WIDTH'(1);    end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_CHK;
            S_CHK:      w_next = r_m[0] ? S_TOMONT : S_FIN;
            S_TOMONT:   if (w_mm_last) w_next = S_INIT;
            S_INIT:     if (w_mm_last) w_next = S_SQR;
            S_SQR:      if (w_mm_last) begin
                            if (w_do_mul)      w_next = S_MUL;
                            else if (w_k_zero) w_next = S_FROMMONT;
                            else               w_next = S_SQR;
                        end
            S_MUL:      if (w_mm_last) w_next = w_k_zero ? S_FROMMONT : S_SQR;
            S_FROMMONT: if (w_mm_last) w_next = S_FIN;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0; r_m <= '0; r_r2 <= '0; r_y <= '0;
            r_xm <= '0; r_acc <= '0; r_z <= '0;
            r_opa <= '0; r_opb <= '0; r_A <= '0;
            r_cnt <= '0; r_k <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_x    <= x;
                    r_y    <= y;
                    r_m    <= m;
                    r_r2   <= r2;
                    r_k    <= KW'(EXP_W - 1);
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
                S_CHK: if (!r_m[0]) begin
                    r_err <= 1'b1;
                    r_z   <= '0;
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase

            if (w_in_mm) begin
                if (r_cnt == '0) begin
                    r_A   <= '0;
                    r_opa <= w_lda;
                    r_opb <= w_ldb;
                    r_cnt <= r_cnt + CW'(1);
                end else if (!w_mm_last) begin
                    r_A   <= w_add_m >> 1;
                    r_opa <= r_opa >> 1;
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_cnt <= '0;
                    case (r_state)
                        S_TOMONT:     r_xm  <= w_res;
                        S_INIT,
                        S_SQR:        r_acc <= w_res;
                        S_MUL:        if (w_ybit) r_acc <= w_res;
                        S_FROMMONT:   r_z   <= w_res;
                        default:      ;
                    endcase
                    // Move to the next exponent bit once this bit's last product is done
                    if (((r_state == S_SQR) && !w_do_mul) || (r_state == S_MUL))
                        if (!w_k_zero) r_k <= r_k - KW'(1);
                end
            end
        end
    end

    assign z    = r_z;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_mont_expo_param.sv
module tb_mont_expo_param;

    localparam int W = 16;
    localparam int E = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] x, m, r2;
    logic [E-1:0] y;
    logic [W-1:0] z;
    logic         busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mont_expo_param #(.WIDTH(W), .EXP_W(E)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x(x), .y(y), .m(m), .r2(r2),
        .z(z), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: right-to-left binary exponentiation in plain integer arithmetic
    function automatic longint ref_pow(longint b, longint e, longint md);
        longint r = 1 % md;
        b = b % md;
        while (e != 0) begin
            if (e[0]) r = (r * b) % md;
            b = (b * b) % md;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic longint ref_r2(longint md);
        return (64'd1 << (2 * W)) % md;
    endfunction

    function automatic int ref_lat(logic [E-1:0] e);
`ifdef MONT_EXPO_CONST_TIME_EN
        return (3 + 2 * E) * (W + 2) + 2;
`else
        return (3 + E + $countones(e)) * (W + 2) + 2;
`endif
    endfunction

    // One transaction: accept, optionally poke start while busy, wait for done
    task automatic run(input logic [W-1:0] xx, input logic [E-1:0] yy, input logic [W-1:0] mm,
                       input logic [W-1:0] rr, input bit poke,
                       output logic [W-1:0] oz, output logic oerr, output int cyc);
        @(negedge clk);
        x = xx; y = yy; m = mm; r2 = rr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_done", 64'(done), 64'd0);
        chk("accept_err",  64'(err),  64'd0);
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (poke && (cyc == 50 || cyc == 51)) begin
                start = 1'b1;
                x = W'($urandom); y = E'($urandom); m = W'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (cyc >= 3000) chk("timeout", 64'(cyc), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        oz = z;
        oerr = err;
    endtask

    logic [W-1:0] rz;
    logic         rerr;
    int           lat;

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0; m = '0; r2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;

        // 3^5 mod 0xFFF1
        run(16'd3, 16'd5, 16'hFFF1, W'(ref_r2(64'hFFF1)), 1'b0, rz, rerr, lat);
        chk("x3y5_z", 64'(rz), 64'(ref_pow(3, 5, 64'hFFF1)));
        chk("x3y5_err", 64'(rerr), 64'd0);
        chk("x3y5_lat", 64'(lat), 64'(ref_lat(16'd5)));
        repeat (5) @(posedge clk);
        #1;
        chk("hold_z", 64'(z), 64'd243);
        chk("hold_done", 64'(done), 64'd1);

        // Fermat: 2^(p-1) mod p
        run(16'd2, 16'hFFF0, 16'hFFF1, W'(ref_r2(64'hFFF1)), 1'b0, rz, rerr, lat);
        chk("fermat_z", 64'(rz), 64'd1);
        chk("fermat_lat", 64'(lat), 64'(ref_lat(16'hFFF0)));

        run(16'd1234, 16'd0, 16'hFFF1, W'(ref_r2(64'hFFF1)), 1'b0, rz, rerr, lat);
        chk("y0_z", 64'(rz), 64'd1);
        run(16'd0, 16'd7, 16'hFFF1, W'(ref_r2(64'hFFF1)), 1'b0, rz, rerr, lat);
        chk("x0_z", 64'(rz), 64'd0);

        run(16'd0, 16'd9, 16'd1, 16'd0, 1'b0, rz, rerr, lat);
        chk("m1_z", 64'(rz), 64'd0);
        chk("m1_err", 64'(rerr), 64'd0);

        run(16'd3, 16'd5, 16'h1000, 16'd0, 1'b0, rz, rerr, lat);
        chk("even_lat", 64'(lat), 64'd2);
        chk("even_err", 64'(rerr), 64'd1);
        chk("even_z", 64'(rz), 64'd0);

        // Valid start after the reject; run() checks err/done cleared on accept
        run(16'd3, 16'd5, 16'hFFF1, W'(ref_r2(64'hFFF1)), 1'b0, rz, rerr, lat);
        chk("after_even_z", 64'(rz), 64'd243);

        // Reset during the first squaring
        @(negedge clk);
        x = 16'd3; y = 16'd5; m = 16'hFFF1; r2 = W'(ref_r2(64'hFFF1)); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_z", 64'(z), 64'd0);
        run(16'd3, 16'd5, 16'hFFF1, W'(ref_r2(64'hFFF1)), 1'b0, rz, rerr, lat);
        chk("post_rst_z", 64'(rz), 64'd243);

        // Random odd moduli, start pokes while busy on odd iterations
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] rm, rx;
            logic [E-1:0] ry;
            rm = W'($urandom_range(3, 65535)) | 16'd1;
            rx = W'($urandom % rm);
            ry = (t % 8 == 0) ? E'(0) : E'($urandom);
            run(rx, ry, rm, W'(ref_r2(64'(rm))), t[0], rz, rerr, lat);
            chk("rand_z", 64'(rz), 64'(ref_pow(64'(rx), 64'(ry), 64'(rm))));
            chk("rand_err", 64'(rerr), 64'd0);
            chk("rand_lat", 64'(lat), 64'(ref_lat(ry)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
